fifo_uart_tx: RTL and testbench

- Downstream drain stage for the 8-deep byte FIFO.
- Pops one byte whenever the FIFO reports data, then serialises it as an asynchronous frame: 1 start bit, 8 data bits LSB first, optional even parity, 1 stop bit.
- Also latches the FIFO overflow flag as a sticky status bit and counts completed frames for host visibility.

---
 rtl/fifo_uart_tx.sv | 137 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops bytes from an 8-deep FIFO and serialises them as
// 8N1 (or 8E1) UART frames; also keeps a sticky overflow flag and a frame counter.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_ready,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_overflow,
  output logic        fifo_read,
  output logic        tx,
  output logic        busy,
  output logic        ovf_sticky,
  input  logic        ovf_clr,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic last_baud;
  logic pop;

  assign last_baud = (baud_q == BAUD_LAST);
  assign pop = enable & fifo_ready &
               ((state_q == S_IDLE) | ((state_q == S_STOP) & last_baud));
  assign fifo_read = pop & ~rst;

  always_comb begin
    state_d       = state_q;
    baud_d        = last_baud ? '0 : baud_q + 16'd1;
    bit_d         = bit_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: baud_d = '0;
      S_START: begin
        if (last_baud) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (last_baud) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (last_baud) state_d = S_STOP;
      end
      S_STOP: begin
        if (last_baud) begin
          state_d       = S_IDLE;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop overrides the STOP->IDLE return, giving back-to-back frames.
    if (pop) begin
      state_d  = S_START;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = fifo_data;
      parity_d = ^fifo_data;
    end

    // tx/busy are registered from the next state so they line up with it.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);

    ovf_d = fifo_overflow | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      ovf_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      ovf_q         <= ovf_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign ovf_sticky  = ovf_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4: one instance without
// parity, one with even parity.
module tb_fifo_uart_tx;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, fifo_ready, fifo_overflow, ovf_clr;
  logic [7:0]  fifo_data;
  logic        fifo_read, tx, busy, ovf_sticky;
  logic [15:0] frame_count;

  logic        p_enable, p_ready;
  logic [7:0]  p_data;
  logic        p_read, p_tx, p_busy, p_ovf;
  logic [15:0] p_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_fc  = '0;
  logic [15:0] exp_pfc = '0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_ready(fifo_ready),
    .fifo_data(fifo_data), .fifo_overflow(fifo_overflow), .fifo_read(fifo_read),
    .tx(tx), .busy(busy), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr),
    .frame_count(frame_count)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut_p (
    .clk(clk), .rst(rst), .enable(p_enable), .fifo_ready(p_ready),
    .fifo_data(p_data), .fifo_overflow(1'b0), .fifo_read(p_read),
    .tx(p_tx), .busy(p_busy), .ovf_sticky(p_ovf), .ovf_clr(1'b0),
    .frame_count(p_count)
  );

  typedef struct {
    logic rst;
    logic ovf;
    logic clr;
    logic exp_sticky;
  } ovf_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change at posedge+1, outputs are sampled at posedge+2.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Frame bit index: 0 start, 1..8 data LSB first, 9 parity (if enabled), then stop.
  function automatic logic frame_bit(input logic [7:0] d, input int unsigned idx, input bit par);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && par) return ^d;
    return 1'b1;
  endfunction

  task automatic frame_check(input bit par, input logic [7:0] d);
    int unsigned len;
    len = (10 + (par ? 1 : 0)) * CPB;
    if (par) begin
      p_enable = 1'b1; p_ready = 1'b1; p_data = d;
    end else begin
      enable = 1'b1; fifo_ready = 1'b1; fifo_data = d;
    end
    #1;
    check("pop_strobe", par ? p_read : fifo_read, 1);
    next_cycle();
    if (par) begin
      p_ready = 1'b0; p_data = ~d;
    end else begin
      fifo_ready = 1'b0; fifo_data = ~d;
    end
    for (int unsigned k = 0; k < len; k++) begin
      #1;
      check("frame_tx", par ? p_tx : tx, frame_bit(d, k / CPB, par));
      check("frame_busy", par ? p_busy : busy, 1);
      check("frame_noread", par ? p_read : fifo_read, 0);
      next_cycle();
    end
    #1;
    if (par) begin
      exp_pfc++;
      check("frame_end_busy", p_busy, 0);
      check("frame_end_count", p_count, exp_pfc);
    end else begin
      exp_fc++;
      check("frame_end_busy", busy, 0);
      check("frame_end_tx", tx, 1);
      check("frame_end_count", frame_count, exp_fc);
    end
    next_cycle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ovf_vec_t    ovec[$];
    logic [7:0]  q[$];
    logic [7:0]  sent[$];
    logic [31:0] pk;

    rst = 1'b1; enable = 1'b0; fifo_ready = 1'b0; fifo_data = '0;
    fifo_overflow = 1'b0; ovf_clr = 1'b0;
    p_enable = 1'b0; p_ready = 1'b0; p_data = '0;
    repeat (3) next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      #1;
      pk = {13'd0, tx, busy, fifo_read, frame_count};
      check("reset_idle", pk, {13'd0, 1'b1, 1'b0, 1'b0, 16'd0});
      check("reset_ovf", ovf_sticky, 0);
      next_cycle();
    end

    ovec = '{
      '{1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0}
    };
    foreach (ovec[i]) begin
      rst = ovec[i].rst; fifo_overflow = ovec[i].ovf; ovf_clr = ovec[i].clr;
      next_cycle();
      #1;
      check("ovf_sticky", ovf_sticky, ovec[i].exp_sticky);
    end
    rst = 1'b0; fifo_overflow = 1'b0; ovf_clr = 1'b0;
    next_cycle();

    // Reset in the middle of DATA aborts the frame.
    enable = 1'b1; fifo_ready = 1'b1; fifo_data = 8'h55;
    #1;
    check("abort_pop", fifo_read, 1);
    next_cycle();
    fifo_ready = 1'b0;
    repeat (9) next_cycle();
    #1;
    check("abort_busy_before", busy, 1);
    rst = 1'b1; fifo_ready = 1'b1; fifo_data = 8'hC3;
    #1;
    check("read_forced_low_in_rst", fifo_read, 0);
    next_cycle();
    rst = 1'b0; fifo_ready = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    for (int i = 0; i < 45; i++) begin
      #1;
      check("abort_idle", {tx, frame_count}, {1'b1, 16'd0});
      next_cycle();
    end

    frame_check(1'b0, 8'hA5);

    // Three queued bytes drained back to back, 40 cycles apart.
    q = '{8'h00, 8'hFF, 8'h3C};
    sent = q;
    enable = 1'b1;
    for (int unsigned c = 0; c <= 120; c++) begin
      fifo_ready = (q.size() != 0);
      fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
      #1;
      check("b2b_read", fifo_read, ((c % 40) == 0) && (c < 120));
      if (c > 0) begin
        check("b2b_tx", tx, frame_bit(sent[(c-1)/40], ((c-1) % 40) / CPB, 1'b0));
        check("b2b_busy", busy, 1);
      end
      if (fifo_read) void'(q.pop_front());
      next_cycle();
    end
    exp_fc += 16'd3;
    #1;
    check("b2b_end_busy", busy, 0);
    check("b2b_count", frame_count, exp_fc);
    next_cycle();

    frame_check(1'b1, 8'h07);
    frame_check(1'b1, 8'h03);

    // enable dropped mid-frame with more data waiting.
    enable = 1'b1; fifo_ready = 1'b1; fifo_data = 8'h12;
    for (int unsigned c = 0; c < 60; c++) begin
      if (c == 1) fifo_data = 8'h34;
      if (c == 10) enable = 1'b0;
      #1;
      check("en_read", fifo_read, c == 0);
      if (c >= 1 && c <= 40) check("en_tx", tx, frame_bit(8'h12, (c-1) / CPB, 1'b0));
      if (c >= 41) check("en_idle", {busy, tx}, {1'b0, 1'b1});
      next_cycle();
    end
    exp_fc++;
    enable = 1'b1;
    #1;
    check("en_reassert_read", fifo_read, 1);
    check("en_count", frame_count, exp_fc);
    next_cycle();
    fifo_ready = 1'b0;
    for (int unsigned c = 0; c < 40; c++) begin
      #1;
      check("en_tx2", tx, frame_bit(8'h34, c / CPB, 1'b0));
      next_cycle();
    end
    exp_fc++;
    #1;
    check("en_count2", frame_count, exp_fc);
    check("en_busy2", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
